per_transmissor: RTL and testbench

Peripheral-side transmitter for the return path of the 4-bit send/ack link: the peripheral buffers locally produced words in a small FIFO and delivers them to the CPU over a 4-phase send/ack handshake. It is the initiating end of the peripheral→CPU direction. The CPU-side receiver raises ack to capture each word.

---
 rtl/per_transmissor.sv | 92 +++++++++
 tb/tb_per_transmissor.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/per_transmissor.sv
// Peripheral-to-CPU transmitter: a small word FIFO drained over a 4-phase send/ack handshake.
// Every output is a register or a decode of registers, so no path runs from per_ack or wr_en to an output.
module per_transmissor #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 4
) (
  input  logic                     per_clock,
  input  logic                     per_reset,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_dados,
  input  logic                     ovf_clr,
  input  logic                     per_ack,
  output logic                     per_send,
  output logic [DATA_W-1:0]        per_dados,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND     = 2'd1,
    WAIT_LOW = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic                push, pop, load;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign per_send = (state_q == SEND);

  // full is registered, so a push in the same cycle as a pop is still dropped.
  assign push = wr_en && !full;

  // NOTE: every variable driven here gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty && !per_ack) begin
          load    = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (per_ack) begin
          pop     = 1'b1;
          state_d = WAIT_LOW;
        end
      end
      WAIT_LOW: begin
        if (!per_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: storage has no reset; emptiness is tracked by count, so stale words are never read.
  always_ff @(posedge per_clock) begin
    if (push) mem[wr_ptr] <= wr_dados;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge per_clock or negedge per_reset) begin
    if (!per_reset) begin
      state_q   <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      per_dados <= '0;
    end else begin
      state_q <= state_d;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
      if (wr_en && full)  overflow <= 1'b1;
      else if (ovf_clr)   overflow <= 1'b0;
      if (load) per_dados <= mem[rd_ptr];
    end
  end

endmodule

// File: tb/tb_per_transmissor.sv
// Self-checking bench for per_transmissor: directed scenarios plus randomized traffic,
// compared every cycle against a queue-based reference of the link behaviour.
module tb_per_transmissor;

  localparam int DATA_W = 4;
  localparam int DEPTH  = 4;

  logic              per_clock = 1'b0;
  logic              per_reset;
  logic              wr_en, ovf_clr, per_ack;
  logic [DATA_W-1:0] wr_dados;
  logic              per_send, full, empty, overflow;
  logic [DATA_W-1:0] per_dados;
  logic [$clog2(DEPTH):0] count;

  per_transmissor #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .per_clock (per_clock),
    .per_reset (per_reset),
    .wr_en     (wr_en),
    .wr_dados  (wr_dados),
    .ovf_clr   (ovf_clr),
    .per_ack   (per_ack),
    .per_send  (per_send),
    .per_dados (per_dados),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow)
  );

  always #5 per_clock = ~per_clock;

  int n_checks = 0;
  int n_errors = 0;

  // Reference: queued words, link phase (0 idle, 1 word offered, 2 waiting for ack release),
  // word currently on the bus, sticky overflow, and the order in which words were accepted.
  logic [DATA_W-1:0] m_q[$];
  logic [DATA_W-1:0] m_sent[$];
  int                m_phase;
  logic [DATA_W-1:0] m_bus;
  logic              m_ovf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_phase = 0;
    m_bus   = '0;
    m_ovf   = 1'b0;
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".send"},  32'(per_send),  32'(m_phase == 1));
    check({tag, ".dados"}, 32'(per_dados), 32'(m_bus));
    check({tag, ".count"}, 32'(count),     32'(m_q.size()));
    check({tag, ".empty"}, 32'(empty),     32'(m_q.size() == 0));
    check({tag, ".full"},  32'(full),      32'(m_q.size() == DEPTH));
    check({tag, ".ovf"},   32'(overflow),  32'(m_ovf));
  endtask

  // Apply one cycle of inputs, advance the reference by one edge, then compare.
  task automatic step(input logic wr, input logic [DATA_W-1:0] d,
                      input logic clr, input logic ack, input string tag);
    bit was_full, do_push;
    wr_en = wr; wr_dados = d; ovf_clr = clr; per_ack = ack;
    @(posedge per_clock);
    was_full = (m_q.size() == DEPTH);
    do_push  = wr && !was_full;
    case (m_phase)
      0: if (m_q.size() > 0 && !ack) begin m_bus = m_q[0]; m_phase = 1; end
      1: if (ack) begin m_sent.push_back(m_q.pop_front()); m_phase = 2; end
      default: if (!ack) m_phase = 0;
    endcase
    if (do_push) m_q.push_back(d);
    if (wr && was_full) m_ovf = 1'b1;
    else if (clr)       m_ovf = 1'b0;
    #1;
    compare_all(tag);
  endtask

  task automatic idle_cycle(input logic ack, input string tag);
    step(1'b0, '0, 1'b0, ack, tag);
  endtask

  // Handshake like a prompt CPU until the FIFO is empty and the link is idle.
  task automatic drain(input string tag);
    for (int i = 0; i < 200; i++) begin
      if (m_q.size() == 0 && m_phase == 0) break;
      idle_cycle(m_phase == 1, tag);
    end
    check({tag, ".drained"}, 32'(empty), 32'd1);
  endtask

  task automatic do_reset();
    per_reset = 1'b0;
    model_reset();
    #2;
    compare_all("reset");
    @(negedge per_clock);
    per_reset = 1'b1;
  endtask

  initial begin
    wr_en = 0; wr_dados = '0; ovf_clr = 0; per_ack = 0;
    model_reset();
    do_reset();

    // Single transfer: send appears one edge after the push edge.
    step(1'b1, 4'h5, 1'b0, 1'b0, "single_push");
    idle_cycle(1'b0, "single_launch");
    check("single_word", 32'(per_dados), 32'h5);
    idle_cycle(1'b0, "single_hold");
    idle_cycle(1'b1, "single_ack");
    check("single_count0", 32'(count), 32'd0);
    idle_cycle(1'b1, "single_ackhold");
    idle_cycle(1'b0, "single_release");
    idle_cycle(1'b0, "single_quiet");
    check("single_nosend", 32'(per_send), 32'd0);

    // Burst of six pushes into a depth-4 FIFO with no ack.
    m_sent.delete();
    for (int i = 1; i <= 6; i++) begin
      step(1'b1, DATA_W'(i), 1'b0, 1'b0, "burst_push");
      if (i == 4) check("burst_full", 32'(full), 32'd1);
      if (i == 5) check("burst_ovf", 32'(overflow), 32'd1);
    end
    drain("burst_drain");
    check("burst_n", 32'(m_sent.size()), 32'd4);
    for (int i = 0; i < 4 && i < m_sent.size(); i++)
      check("burst_order", 32'(m_sent[i]), 32'(i + 1));
    step(1'b0, '0, 1'b1, 1'b0, "ovf_clr");
    check("ovf_cleared", 32'(overflow), 32'd0);

    // Stalled receiver: offered word must stay put for 20 cycles.
    step(1'b1, 4'h7, 1'b0, 1'b0, "stall_push0");
    step(1'b1, 4'h8, 1'b0, 1'b0, "stall_push1");
    for (int i = 0; i < 20; i++) idle_cycle(1'b0, "stall");
    check("stall_word", 32'(per_dados), 32'h7);
    step(1'b1, 4'h9, 1'b0, 1'b1, "push_and_pop");
    check("pp_count2", 32'(count), 32'd2);
    idle_cycle(1'b0, "pp_release");
    drain("stall_drain");

    // Stuck ack from reset blocks launch until it falls.
    per_ack = 1'b1;
    do_reset();
    step(1'b1, 4'hA, 1'b0, 1'b1, "stuck_push");
    for (int i = 0; i < 5; i++) idle_cycle(1'b1, "stuck_hold");
    check("stuck_nosend", 32'(per_send), 32'd0);
    idle_cycle(1'b0, "stuck_drop");
    check("stuck_word", 32'(per_dados), 32'hA);
    check("stuck_send", 32'(per_send), 32'd1);
    drain("stuck_drain");

    // Asynchronous reset while offering a word with three queued.
    for (int i = 0; i < 3; i++) step(1'b1, DATA_W'(4'h3 + i), 1'b0, 1'b0, "mid_push");
    check("mid_in_send", 32'(per_send), 32'd1);
    #2;
    per_reset = 1'b0;
    model_reset();
    #1;
    compare_all("mid_reset");
    @(negedge per_clock);
    per_reset = 1'b1;
    step(1'b1, 4'hC, 1'b0, 1'b0, "after_push");
    idle_cycle(1'b0, "after_launch");
    check("after_word", 32'(per_dados), 32'hC);
    drain("after_drain");

    // Randomized traffic with an erratic receiver; wraps the pointers many times.
    m_sent.delete();
    for (int i = 0; i < 400; i++) begin
      logic a;
      case (m_phase)
        1:       a = ($urandom_range(0, 1) == 1);
        2:       a = ($urandom_range(0, 9) < 3);
        default: a = ($urandom_range(0, 9) == 0);
      endcase
      step($urandom_range(0, 9) < 4, DATA_W'($urandom), $urandom_range(0, 9) == 0, a, "rand");
      check("rand_bound", 32'(count <= DEPTH), 32'd1);
    end
    drain("rand_drain");
    check("rand_wrapped", 32'(m_sent.size() > 2 * DEPTH), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
